// File: rtl/serial_frame_tx.sv
// Purpose : parallel-to-serial frame transmitter feeding the x_in input of the
//           sequence-detector blocks; MSB first, one bit per clock.
// Latency : first bit is visible in the cycle right after the accept edge.
// Backpr. : data_ready is high only in IDLE; a held data_valid waits for it.
//           The hold input freezes the shifter, sampled at each clock edge.
// Ports   : clock/reset (async, active-high); data_in/data_valid/data_ready
//           word handshake; hold stall input; x_out/x_valid serial stream;
//           busy (SHIFT or GAP); frame_done pulse on the last frame bit.
// Option  : define SERIAL_FRAME_TX_PARITY_EN to append an even-parity bit.
module serial_frame_tx #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             hold,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             frame_done
);

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int                CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(FRAME_LEN);
    localparam logic [3:0]        GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_LEN-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           gap_q, gap_d;
    logic                 x_out_q, x_out_d;
    logic                 x_valid_q, x_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Word as it enters the shifter; the parity bit rides in the LSB slot.
    logic [FRAME_LEN-1:0] load_word;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    assign load_word = {data_in, ^data_in};
`else
    assign load_word = data_in;
`endif

    // Shared emit path: on the accept edge it works from the incoming word,
    // otherwise from the live shift register, so the first bit costs no
    // extra cycle.
    logic [FRAME_LEN-1:0] src_sr;
    logic [CNT_W-1:0]     src_cnt;
    logic                 emit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        x_out_d   = x_out_q;
        x_valid_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        src_sr    = sr_q;
        src_cnt   = cnt_q;
        emit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                x_out_d = 1'b0;
                if (data_valid) begin
                    state_d = S_SHIFT;
                    busy_d  = 1'b1;
                    sr_d    = load_word;
                    cnt_d   = '0;
                    src_sr  = load_word;
                    src_cnt = '0;
                    emit    = !hold;
                end
            end
            S_SHIFT: begin
                // cnt_q == CNT_END means the last bit is on the wire now.
                if (cnt_q == CNT_END) begin
                    x_out_d = 1'b0;
                    gap_d   = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    // Under hold x_out_d keeps its old value and nothing moves.
                    emit = !hold;
                end
            end
            S_GAP: begin
                x_out_d = 1'b0;
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                x_out_d = 1'b0;
            end
        endcase

        if (emit) begin
            x_out_d   = src_sr[FRAME_LEN-1];
            x_valid_d = 1'b1;
            sr_d      = src_sr << 1;
            cnt_d     = src_cnt + CNT_W'(1);
            done_d    = (src_cnt == CNT_LAST);
        end
    end

    assign data_ready = (state_q == S_IDLE);
    assign x_out      = x_out_q;
    assign x_valid    = x_valid_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
